// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and a single-port SRAM.
// The arbiter uses the slave modport; the requester/SRAM side uses the master modport.
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, sram_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, sram_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM between an instruction-fetch port and a data port.
// Requests are accepted combinationally; responses follow exactly one cycle later.
module sram_port_arbiter (
  input  logic                    clk,
  input  logic                    resetn,
  sram_port_arbiter_if.slave      bus,
  output logic [15:0]             inst_cnt,
  output logic [15:0]             data_cnt
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
  typedef enum logic {PORT_INST = 1'b0, PORT_DATA = 1'b1} port_t;

  state_t      state_q;
  port_t       resp_port_q;
  port_t       last_grant_q;
  logic        resp_is_write_q;
  logic [15:0] inst_cnt_q, inst_cnt_d;
  logic [15:0] data_cnt_q, data_cnt_d;

  logic grant_inst, grant_data, accept;
  logic resp_valid, inst_ok, data_ok;

  // Grants are masked during reset so nothing leaks onto the SRAM bus.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (resetn) begin
      if (bus.inst_req && bus.data_req) begin
        grant_inst = (last_grant_q == PORT_DATA);
        grant_data = (last_grant_q == PORT_INST);
      end else begin
        grant_inst = bus.inst_req;
        grant_data = bus.data_req;
      end
    end
  end

  assign accept = grant_inst | grant_data;

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_addr  = 32'h0;
    bus.sram_wdata = 32'h0;
    if (grant_inst) begin
      bus.sram_en   = 1'b1;
      bus.sram_addr = bus.inst_addr;
    end else if (grant_data) begin
      bus.sram_en    = 1'b1;
      bus.sram_we    = bus.data_we;
      bus.sram_addr  = bus.data_addr;
      bus.sram_wdata = bus.data_wdata;
    end
  end

  assign bus.inst_addr_ok = grant_inst;
  assign bus.data_addr_ok = grant_data;

  assign inst_cnt_d = (grant_inst && inst_cnt_q != 16'hFFFF) ? inst_cnt_q + 16'd1 : inst_cnt_q;
  assign data_cnt_d = (grant_data && data_cnt_q != 16'hFFFF) ? data_cnt_q + 16'd1 : data_cnt_q;

  // RESP lasts one cycle per accept; a fresh accept keeps it there for back-to-back traffic.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      resp_port_q     <= PORT_INST;
      resp_is_write_q <= 1'b0;
      last_grant_q    <= PORT_DATA;
      inst_cnt_q      <= 16'h0;
      data_cnt_q      <= 16'h0;
    end else begin
      state_q    <= accept ? RESP : IDLE;
      inst_cnt_q <= inst_cnt_d;
      data_cnt_q <= data_cnt_d;
      if (accept) begin
        resp_port_q     <= grant_data ? PORT_DATA : PORT_INST;
        last_grant_q    <= grant_data ? PORT_DATA : PORT_INST;
        resp_is_write_q <= grant_data & bus.data_we;
      end
    end
  end

  assign resp_valid = (state_q == RESP);
  assign inst_ok    = resp_valid && (resp_port_q == PORT_INST);
  assign data_ok    = resp_valid && (resp_port_q == PORT_DATA);

  assign bus.inst_data_ok = inst_ok;
  assign bus.data_data_ok = data_ok;
  assign bus.inst_rdata   = inst_ok ? bus.sram_rdata : 32'h0;
  assign bus.data_rdata   = (data_ok && !resp_is_write_q) ? bus.sram_rdata : 32'h0;

  assign inst_cnt = inst_cnt_q;
  assign data_cnt = data_cnt_q;

endmodule
